stopwatch_lap_core: RTL

Parametrised successor to the single-channel service stopwatch. It adds configurable tick resolution and range, a lap-capture buffer with recall, overflow flagging, and a one-cycle finish pulse. It sits under the service-mode selector, takes one SPDT enable and three debounced push buttons, and drives the 16-bit BCD bus of the four-digit 7-segment mux.

---
 rtl/stopwatch_lap_core.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: start/pause/clear FSM, prescaled counter, BCD display, overflow and finish flags.
// Lap buffer with recall is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap_core #(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int TICKS_PER_SEC = 100,
    parameter int SEC_MAX       = 99,
    parameter int LAP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        push_m,
    input  logic        push_l,
    input  logic        push_r,
    output logic [15:0] segments,
    output logic        running,
    output logic [3:0]  lap_count,
    output logic        lap_view,
    output logic        overflow,
    output logic        finish,
    output logic [1:0]  fsm_state
);
    localparam int RATIO = CLOCK_FREQ / TICKS_PER_SEC;
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RATIO - 1);
    localparam logic [6:0]    FRAC_LAST  = 7'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    SEC_LAST   = 7'(SEC_MAX);
    localparam logic [3:0]    LAP_FULL   = 4'(LAP_DEPTH);
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t        state, state_next;
    logic          m_prev, l_prev, r_prev, en_prev;
    logic          m_ev, l_ev, r_ev;
    logic [PW-1:0] presc;
    logic [6:0]    sec, frac;
    logic [3:0]    lap_cnt, view_idx;
    logic          tick, do_clear, do_start, do_lap, do_recall;
    logic [6:0]    show_sec, show_frac, show_hund;

    // Button events are registered, so a press acts one cycle after it is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_prev  <= 1'b0;
            l_prev  <= 1'b0;
            r_prev  <= 1'b0;
            m_ev    <= 1'b0;
            l_ev    <= 1'b0;
            r_ev    <= 1'b0;
            en_prev <= 1'b0;
            finish  <= 1'b0;
        end else begin
            m_prev  <= push_m;
            l_prev  <= push_l;
            r_prev  <= push_r;
            m_ev    <= push_m & ~m_prev;
            l_ev    <= push_l & ~l_prev;
            r_ev    <= push_r & ~r_prev;
            en_prev <= enable;
            finish  <= en_prev & ~enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Priority: enable low, then push_m, push_l, push_r; lower events are dropped.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_start   = 1'b0;
        do_lap     = 1'b0;
        do_recall  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            do_clear   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARMED;
                    do_clear   = 1'b1;
                end
                ARMED: begin
                    if (m_ev) begin
                        state_next = RUN;
                        do_start   = 1'b1;
                    end
                end
                RUN: begin
                    if (m_ev)      state_next = PAUSE;
                    else if (l_ev) do_lap     = LAP_ON;
                    else if (r_ev) do_recall  = LAP_ON && (lap_cnt != 4'd0);
                end
                PAUSE: begin
                    if (m_ev) begin
                        state_next = RUN;
                    end else if (l_ev) begin
                        state_next = ARMED;
                        do_clear   = 1'b1;
                    end else if (r_ev) begin
                        do_recall  = LAP_ON && (lap_cnt != 4'd0);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            presc    <= '0;
            sec      <= 7'd0;
            frac     <= 7'd0;
            overflow <= 1'b0;
        end else begin
            // Pause holds the prescaler so resume loses no partial tick.
            if (do_start)           presc <= '0;
            else if (state == RUN)  presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (frac == FRAC_LAST) begin
                    frac <= 7'd0;
                    if (sec == SEC_LAST) begin
                        sec      <= 7'd0;
                        overflow <= 1'b1;
                    end else begin
                        sec <= sec + 7'd1;
                    end
                end else begin
                    frac <= frac + 7'd1;
                end
            end
        end
    end

    // view_idx: 0 = live, k = k-th newest lap.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            lap_cnt  <= 4'd0;
            view_idx <= 4'd0;
        end else if (do_lap) begin
            view_idx <= 4'd0;
            if (lap_cnt != LAP_FULL) lap_cnt <= lap_cnt + 4'd1;
        end else if (do_recall) begin
            view_idx <= (view_idx == lap_cnt) ? 4'd0 : view_idx + 4'd1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [13:0]   lap_mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [4:0]    rd_sum;
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk) begin
        if (reset || do_clear)
            wr_ptr <= '0;
        else if (do_lap)
            wr_ptr <= (wr_ptr == AW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    end

    // Captured from the registers, so a lap coinciding with a tick keeps the pre-tick time.
    always_ff @(posedge clk) begin
        if (do_lap) lap_mem[wr_ptr] <= {sec, frac};
    end

    always_comb begin
        rd_sum = 5'(wr_ptr) + 5'(LAP_DEPTH) - 5'(view_idx);
        if (rd_sum >= 5'(LAP_DEPTH)) rd_sum = rd_sum - 5'(LAP_DEPTH);
        rd_idx = AW'(rd_sum);
    end

    always_comb begin
        show_sec  = sec;
        show_frac = frac;
        if (view_idx != 4'd0) {show_sec, show_frac} = lap_mem[rd_idx];
    end
`else
    assign show_sec  = sec;
    assign show_frac = frac;
`endif

    // Fractions are always displayed as hundredths.
    assign show_hund = (TICKS_PER_SEC == 10) ? 7'(show_frac * 7'd10) : show_frac;

    always_ff @(posedge clk) begin
        if (reset)
            segments <= 16'h0000;
        else
            segments <= {4'(show_sec / 7'd10), 4'(show_sec % 7'd10),
                         4'(show_hund / 7'd10), 4'(show_hund % 7'd10)};
    end

    assign running   = (state == RUN);
    assign lap_count = lap_cnt;
    assign lap_view  = (view_idx != 4'd0);
    assign fsm_state = state;

endmodule
